// File: rtl/ysyx_22041071_pipe_ctrl_pkg.sv
// Shared constants for the ysyx_22041071 pipeline controller.
// Holds the sequencer state encoding, opcode constants and register index width.
package ysyx_22041071_pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned NREG  = 1 << REG_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MD_WAIT  = 2'd1,
    ST_REDIRECT = 2'd2
  } pc_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/ysyx_22041071_ld_scoreboard.sv
// Per-register in-flight load scoreboard; flags a RAW hazard on rs1/rs2.
// Ports: clk/reset, set (issuing load rd), clr (load in WB), rs1/rs2 lookup, raw.
module ysyx_22041071_ld_scoreboard
  import ysyx_22041071_pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_rd,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  output logic             raw
);

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] pend_eff;

  assign clr_mask = clr_en ? (NREG'(1) << clr_rd) : '0;

  // A load sitting in WB is forwardable, so it no longer blocks issue.
  assign pend_eff = pend & ~clr_mask;

  assign raw = (rs1_used && pend_eff[rs1])
            || (rs2_used && pend_eff[rs2]);

  // Clear first so a same-cycle set of the same register wins.
  always_comb begin
    pend_nxt = pend & ~clr_mask;
    if (set_en) pend_nxt[set_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend <= '0;
    else       pend <= pend_nxt;
  end

endmodule

// File: rtl/ysyx_22041071_pipe_ctrl.sv
// Central issue/stall/flush sequencer for the 5-stage ysyx_22041071 core.
// Ports: ID decode info, EX/MD/WB status in; issue, stall, flush, hold, counters out.
module ysyx_22041071_pipe_ctrl
  import ysyx_22041071_pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rd_wen,
  input  logic             id_is_load,
  input  logic             id_is_muldiv,
  input  logic             ex_ready,
  input  logic             ex_redirect,
  input  logic             md_done,
  input  logic             wb_ld_done,
  input  logic [REG_W-1:0] wb_rd,
  output logic             issue,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             hold_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned MW = $clog2(MD_TIMEOUT);
  localparam logic [MW-1:0] MD_LAST = MW'(MD_TIMEOUT - 1);

  pc_state_t   state;
  logic [MW-1:0] md_cnt;
  logic        raw;
  logic        can_issue;
  logic        md_last;
  logic        ld_set;

  ysyx_22041071_ld_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (ld_set),
    .set_rd   (id_rd),
    .clr_en   (wb_ld_done),
    .clr_rd   (wb_rd),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rs1_used (id_rs1_used),
    .rs2_used (id_rs2_used),
    .raw      (raw)
  );

  assign can_issue = id_valid && ex_ready && !raw
                  && !ex_redirect && (state == ST_IDLE);
  assign md_last   = (md_cnt == MD_LAST);
  assign ld_set    = issue && id_is_load && id_rd_wen
                  && (id_rd != '0);

  always_comb begin
    issue       = 1'b0;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    hold_ex     = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (reset) begin
      bubble_ex = id_valid;
    end else begin
      issue = can_issue;
      unique case (state)
        ST_IDLE: begin
          // Flush outranks stall: both registers get cleared.
          if (ex_redirect) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (id_valid && !can_issue) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        ST_REDIRECT: begin
          bubble_ex = 1'b1;
          if (ex_redirect) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          hold_ex  = !md_done && !md_last;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      md_cnt    <= '0;
      md_err    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (id_valid && !issue)
        stall_cnt <= stall_cnt + CNT_W'(1);
      unique case (state)
        ST_IDLE: begin
          if (ex_redirect) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
            state     <= ST_REDIRECT;
          end else if (issue && id_is_muldiv) begin
            md_cnt <= '0;
            state  <= ST_MD_WAIT;
          end
        end
        ST_REDIRECT: begin
          if (ex_redirect)
            flush_cnt <= flush_cnt + CNT_W'(1);
          else
            state <= ST_IDLE;
        end
        ST_MD_WAIT: begin
          if (md_done) begin
            md_cnt <= '0;
            state  <= ST_IDLE;
          end else if (md_last) begin
            md_err <= 1'b1;
            md_cnt <= '0;
            state  <= ST_IDLE;
          end else begin
            md_cnt <= md_cnt + MW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
